// File: rtl/tri_loader.sv
// tri_loader: byte-stream triangle loader for the rasterizer.
// Sorts vertices into scan order, commits to geometry at vsync.
module tri_loader #(
  parameter int COMMIT_ON_VSYNC = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vsync,
  input  logic        resync,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [59:0] geometry,
  output logic        pending
);

  typedef enum logic [2:0] {
    RECV,
    SORT0,
    SORT1,
    SORT2,
    CROSS0,
    CROSS1,
    ORIENT,
    PEND
  } state_t;

  state_t state_q, state_d;

  logic [3:0]  cnt_q, cnt_d;
  logic [9:0]  vx_q [3];
  logic [9:0]  vx_d [3];
  logic [9:0]  vy_q [3];
  logic [9:0]  vy_d [3];

  logic signed [21:0] p0_q, p0_d;
  logic signed [21:0] p1_q, p1_d;

  logic [59:0] shadow_q, shadow_d;
  logic [59:0] geom_q, geom_d;
  logic        pending_q, pending_d;
  logic        in_ready_q, in_ready_d;
  logic        vsync_q;

  logic        xfer;
  logic        vs_edge;
  logic        commit_ok;
  logic [1:0]  v_idx;
  logic [1:0]  sa, sb;

  logic signed [10:0] dx21, dx31, dy21, dy31;
  logic signed [10:0] ma, mb;
  logic signed [21:0] ma_w, mb_w, prod;
  logic signed [22:0] p0_x, p1_x, cross_c;

  logic unused_hi;

  // High-byte bits [7:2] carry no coordinate data.
  assign unused_hi = ^in_data[7:2];

  assign xfer    = in_valid & in_ready_q;
  assign vs_edge = vsync & ~vsync_q;
  assign v_idx   = cnt_q[3:2];

  assign commit_ok = (COMMIT_ON_VSYNC != 0) ? vs_edge : 1'b1;

  // Zero-extended coordinate differences.
  assign dx21 = {1'b0, vx_q[1]} - {1'b0, vx_q[0]};
  assign dx31 = {1'b0, vx_q[2]} - {1'b0, vx_q[0]};
  assign dy21 = {1'b0, vy_q[1]} - {1'b0, vy_q[0]};
  assign dy31 = {1'b0, vy_q[2]} - {1'b0, vy_q[0]};

  // Operand select for the single shared multiplier.
  always_comb begin
    ma = '0;
    mb = '0;
    unique case (state_q)
      CROSS0: begin
        ma = dx21;
        mb = dy31;
      end
      CROSS1: begin
        ma = dy21;
        mb = dx31;
      end
      default: begin
        ma = '0;
        mb = '0;
      end
    endcase
  end

  assign ma_w = {{11{ma[10]}}, ma};
  assign mb_w = {{11{mb[10]}}, mb};
  assign prod = ma_w * mb_w;

  assign p0_x    = {p0_q[21], p0_q};
  assign p1_x    = {p1_q[21], p1_q};
  assign cross_c = p0_x - p1_x;

  // Receive, sort, orient and commit sequencing.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    vx_d      = vx_q;
    vy_d      = vy_q;
    p0_d      = p0_q;
    p1_d      = p1_q;
    shadow_d  = shadow_q;
    geom_d    = geom_q;
    pending_d = pending_q;
    sa        = 2'd0;
    sb        = 2'd1;
    unique case (state_q)
      RECV: begin
        if (resync) begin
          cnt_d = '0;
        end else if (xfer) begin
          if (!cnt_q[0]) begin
            if (cnt_q[1]) vy_d[v_idx][9:8] = in_data[1:0];
            else          vx_d[v_idx][9:8] = in_data[1:0];
          end else begin
            if (cnt_q[1]) vy_d[v_idx][7:0] = in_data;
            else          vx_d[v_idx][7:0] = in_data;
          end
          if (cnt_q == 4'd11) begin
            cnt_d   = '0;
            state_d = SORT0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      SORT0: begin
        sa      = 2'd0;
        sb      = 2'd1;
        state_d = SORT1;
      end
      SORT1: begin
        sa      = 2'd1;
        sb      = 2'd2;
        state_d = SORT2;
      end
      SORT2: begin
        sa      = 2'd0;
        sb      = 2'd1;
        state_d = CROSS0;
      end
      CROSS0: begin
        p0_d    = prod;
        state_d = CROSS1;
      end
      CROSS1: begin
        p1_d    = prod;
        state_d = ORIENT;
      end
      ORIENT: begin
        if (cross_c > 23'sd0) begin
          shadow_d = {vx_q[0], vy_q[0], vx_q[2], vy_q[2],
                      vx_q[1], vy_q[1]};
        end else begin
          shadow_d = {vx_q[0], vy_q[0], vx_q[1], vy_q[1],
                      vx_q[2], vy_q[2]};
        end
        pending_d = 1'b1;
        state_d   = PEND;
      end
      PEND: begin
        if (commit_ok) begin
          geom_d    = shadow_q;
          pending_d = 1'b0;
          state_d   = RECV;
        end
      end
      default: state_d = RECV;
    endcase
    // Strict compare keeps equal-y vertices in arrival order.
    if ((state_q == SORT0 || state_q == SORT1 || state_q == SORT2)
        && (vy_q[sa] > vy_q[sb])) begin
      vx_d[sa] = vx_q[sb];
      vy_d[sa] = vy_q[sb];
      vx_d[sb] = vx_q[sa];
      vy_d[sb] = vy_q[sa];
    end
    in_ready_d = (state_d == RECV);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RECV;
      cnt_q      <= '0;
      vx_q       <= '{default: '0};
      vy_q       <= '{default: '0};
      p0_q       <= '0;
      p1_q       <= '0;
      shadow_q   <= '0;
      geom_q     <= '0;
      pending_q  <= 1'b0;
      in_ready_q <= 1'b0;
      vsync_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      vx_q       <= vx_d;
      vy_q       <= vy_d;
      p0_q       <= p0_d;
      p1_q       <= p1_d;
      shadow_q   <= shadow_d;
      geom_q     <= geom_d;
      pending_q  <= pending_d;
      in_ready_q <= in_ready_d;
      vsync_q    <= vsync;
    end
  end

  assign in_ready = in_ready_q;
  assign geometry = geom_q;
  assign pending  = pending_q;

endmodule

// File: tb/tb_tri_loader.sv
// tb_tri_loader: directed + random bench for tri_loader.
// Expected triangles are queued at send and popped at commit.
module tb_tri_loader;

  logic        clk;
  logic        rst_n;
  logic        vsync;
  logic        resync;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [59:0] geometry;
  logic        pending;

  int n_cmp = 0;
  int n_bad = 0;

  logic [59:0] sb_q [$];
  logic [59:0] prev_geom;

  tri_loader #(.COMMIT_ON_VSYNC(1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .vsync    (vsync),
    .resync   (resync),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .geometry (geometry),
    .pending  (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [59:0] obs,
                     input logic [59:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [59:0] pack(input int x1, y1, x2, y2,
                                       x3, y3);
    return {10'(x1), 10'(y1), 10'(x2), 10'(y2), 10'(x3), 10'(y3)};
  endfunction

  // Reference: stable 3-pass sort on y, then orientation by cross sign.
  function automatic logic [59:0] model(input int x1, y1, x2, y2,
                                        input int x3, y3);
    int x [3];
    int y [3];
    int pa [3];
    int c, t;
    x[0] = x1; y[0] = y1;
    x[1] = x2; y[1] = y2;
    x[2] = x3; y[2] = y3;
    pa[0] = 0; pa[1] = 1; pa[2] = 0;
    for (int i = 0; i < 3; i++) begin
      if (y[pa[i]] > y[pa[i]+1]) begin
        t = x[pa[i]]; x[pa[i]] = x[pa[i]+1]; x[pa[i]+1] = t;
        t = y[pa[i]]; y[pa[i]] = y[pa[i]+1]; y[pa[i]+1] = t;
      end
    end
    c = (x[1]-x[0])*(y[2]-y[0]) - (y[1]-y[0])*(x[2]-x[0]);
    if (c > 0) return pack(x[0], y[0], x[2], y[2], x[1], y[1]);
    return pack(x[0], y[0], x[1], y[1], x[2], y[2]);
  endfunction

  task automatic send_byte(input logic [7:0] d);
    int n;
    in_data  = d;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rdy", {59'd0, in_ready}, 60'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_part(input int x1, y1, x2, y2, x3, y3,
                           input int nbytes);
    int c [6];
    logic [9:0] v;
    logic [7:0] b;
    c[0] = x1; c[1] = y1; c[2] = x2;
    c[3] = y2; c[4] = x3; c[5] = y3;
    for (int k = 0; k < nbytes; k++) begin
      v = 10'(c[k/2]);
      if (k % 2 == 0) b = {6'($urandom), v[9:8]};
      else            b = v[7:0];
      send_byte(b);
    end
  endtask

  task automatic send_tri(input int x1, y1, x2, y2, x3, y3);
    send_part(x1, y1, x2, y2, x3, y3, 12);
  endtask

  task automatic wait_pending();
    int n;
    n = 0;
    while (!pending && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("pend_wait", {59'd0, pending}, 60'd1);
  endtask

  task automatic commit_vsync();
    vsync = 1'b0;
    @(posedge clk); #1;
    vsync = 1'b1;
    @(posedge clk); #1;
    vsync = 1'b0;
  endtask

  task automatic pop_check(input string tag);
    logic [59:0] e;
    n_cmp++;
    assert (sb_q.size() > 0) else begin
      n_bad++;
      $error("FAIL %s observed=empty expected=entry", tag);
    end
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk(tag, geometry, e);
      chk({tag, "_pend"}, {59'd0, pending}, 60'd0);
      chk({tag, "_rdy"}, {59'd0, in_ready}, 60'd1);
      prev_geom = e;
    end
  endtask

  initial begin
    int rx [6];
    rst_n     = 1'b0;
    vsync     = 1'b0;
    resync    = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    prev_geom = '0;

    #2;
    chk("rst_geom", geometry, 60'd0);
    chk("rst_pend", {59'd0, pending}, 60'd0);
    chk("rst_rdy", {59'd0, in_ready}, 60'd0);
    #5 rst_n = 1'b1;
    #1;
    chk("rel_rdy0", {59'd0, in_ready}, 60'd0);
    @(posedge clk); #1;
    chk("rel_rdy1", {59'd0, in_ready}, 60'd1);

    // Ordered y, orientation swap; resync during SORT is ignored.
    sb_q.push_back(pack(100, 50, 50, 300, 200, 300));
    send_tri(100, 50, 200, 300, 50, 300);
    resync = 1'b1;
    @(posedge clk); #1;
    resync = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("lat_n5", {59'd0, pending}, 60'd0);
    @(posedge clk); #1;
    chk("lat_n6", {59'd0, pending}, 60'd1);
    chk("hold_t1", geometry, prev_geom);
    commit_vsync();
    pop_check("tri_ordered");

    // Unsorted y.
    sb_q.push_back(pack(300, 20, 10, 400, 600, 200));
    send_tri(10, 400, 300, 20, 600, 200);
    wait_pending();
    chk("hold_t2", geometry, prev_geom);
    commit_vsync();
    pop_check("tri_unsorted");

    // vsync edge in CROSS0 ignored; collinear passes through.
    vsync = 1'b1;
    sb_q.push_back(pack(0, 0, 5, 5, 10, 10));
    send_tri(0, 0, 5, 5, 10, 10);
    vsync = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    vsync = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
    end
    chk("gate_n5", {59'd0, pending}, 60'd0);
    @(posedge clk); #1;
    chk("gate_n6", {59'd0, pending}, 60'd1);
    @(posedge clk); #1;
    chk("gate_n7", {59'd0, pending}, 60'd1);
    chk("gate_hold", geometry, prev_geom);
    commit_vsync();
    pop_check("tri_collinear");

    // Equal-y tie keeps arrival order, c < 0.
    sb_q.push_back(pack(40, 60, 20, 60, 30, 90));
    send_tri(40, 60, 20, 60, 30, 90);
    wait_pending();
    commit_vsync();
    pop_check("tri_tie");

    // resync mid-packet drops the concurrent byte.
    send_part(900, 900, 900, 900, 900, 900, 5);
    resync   = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hFF;
    @(posedge clk); #1;
    resync   = 1'b0;
    in_valid = 1'b0;
    chk("resync_rdy", {59'd0, in_ready}, 60'd1);
    chk("resync_pend", {59'd0, pending}, 60'd0);
    sb_q.push_back(model(512, 700, 3, 100, 1023, 100));
    send_tri(512, 700, 3, 100, 1023, 100);
    wait_pending();
    chk("resync_hold", geometry, prev_geom);
    commit_vsync();
    pop_check("tri_resync");

    // Random triangles.
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 6; k++) rx[k] = int'($urandom_range(0, 1023));
      sb_q.push_back(model(rx[0], rx[1], rx[2], rx[3], rx[4], rx[5]));
      send_tri(rx[0], rx[1], rx[2], rx[3], rx[4], rx[5]);
      wait_pending();
      commit_vsync();
      pop_check("tri_rand");
    end

    // Async reset during SORT1 with a committed triangle.
    send_tri(1, 2, 3, 4, 5, 6);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_geom", geometry, 60'd0);
    chk("mid_rst_pend", {59'd0, pending}, 60'd0);
    chk("mid_rst_rdy", {59'd0, in_ready}, 60'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid_rel_rdy0", {59'd0, in_ready}, 60'd0);
    @(posedge clk); #1;
    chk("mid_rel_rdy1", {59'd0, in_ready}, 60'd1);
    prev_geom = '0;

    sb_q.push_back(model(700, 10, 800, 500, 20, 30));
    send_tri(700, 10, 800, 500, 20, 30);
    wait_pending();
    chk("post_rst_hold", geometry, prev_geom);
    commit_vsync();
    pop_check("tri_post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
